// File: rtl/fp_pkg.sv
// Shared widths, IEEE-754 single-precision constants and the FSM encoding
// for the multi-cycle add/subtract unit.
package fp_pkg;
   localparam int W       = 32;
   localparam int EW      = 8;
   localparam int SW      = 23;
   localparam int BIAS    = 127;
   localparam int XW      = SW + 5;
   localparam int EXP_MAX = 2 * BIAS + 1;

   localparam logic [W-1:0] QNAN    = 32'h7FC00000;
   localparam logic [W-1:0] POS_INF = 32'h7F800000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_SWAP,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_PACK,
      ST_DONE
   } fsm_state_t;
endpackage

// File: rtl/fp_add_subt_unit_if.sv
// Start/operand request and result/ACK response between the CORDIC control FSM
// (master) and the floating-point add/subtract unit (slave).
interface fp_add_subt_unit_if;
   logic                  Begin_SUM;
   logic                  ADD_SUBT;
   logic [fp_pkg::W-1:0]  Data_X;
   logic [fp_pkg::W-1:0]  Data_Y;
   logic [fp_pkg::W-1:0]  Result;
   logic                  ACK_ADD_SUBT;
   logic                  overflow_flag;
   logic                  underflow_flag;

   modport master (
      output Begin_SUM, ADD_SUBT, Data_X, Data_Y,
      input  Result, ACK_ADD_SUBT, overflow_flag, underflow_flag
   );

   modport slave (
      input  Begin_SUM, ADD_SUBT, Data_X, Data_Y,
      output Result, ACK_ADD_SUBT, overflow_flag, underflow_flag
   );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the extended significand;
// an all-zero input returns XW.
module fp_lzc
   import fp_pkg::*;
(
   input  logic [XW-1:0] din,
   output logic [4:0]    cnt
);

   // Ascending scan so the most significant set bit wins.
   always_comb begin
      cnt = 5'(XW);
      for (int i = 0; i < XW; i++) begin
         if (din[i]) cnt = 5'(XW - 1 - i);
      end
   end

endmodule

// File: rtl/fp_add_subt_unit.sv
// Multi-cycle single-precision adder/subtractor, round toward zero, denormals flushed.
// Fixed latency: start sampled at edge 0, Result/ACK valid after edge 7; starts while busy are dropped.
module fp_add_subt_unit
   import fp_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   fp_add_subt_unit_if.slave bus
);

   fsm_state_t state_q, state_d;
   logic       accept;

   logic [W-1:0]  op_x_q, op_y_q;
   logic          sub_q;

   logic          sx_q, sy_q;
   logic [EW-1:0] ex_q, ey_q;
   logic [SW:0]   mx_q, my_q;
   logic          spec_q;
   logic [W-1:0]  spec_res_q;

   logic          sa_q, eff_sub_q;
   logic [EW-1:0] ea_q, d_q;
   logic [SW:0]   ma_q, mb_q;

   logic [XW-1:0] mb_al_q, sum_q;
   logic          nzero_q;
   logic [9:0]    nexp_q;
   logic [SW-1:0] nfrac_q;

   logic [W-1:0]  result_q;
   logic          ack_q, ovf_q, unf_q;

   // Unpack: special operands short-circuit the whole datapath.
   logic          sy_eff, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, spec_d;
   logic [W-1:0]  spec_res_d;

   always_comb begin
      sy_eff     = op_y_q[W-1] ^ sub_q;
      x_zero     = (op_x_q[W-2:SW] == '0);
      y_zero     = (op_y_q[W-2:SW] == '0);
      x_inf      = (op_x_q[W-2:SW] == '1) && (op_x_q[SW-1:0] == '0);
      y_inf      = (op_y_q[W-2:SW] == '1) && (op_y_q[SW-1:0] == '0);
      x_nan      = (op_x_q[W-2:SW] == '1) && (op_x_q[SW-1:0] != '0);
      y_nan      = (op_y_q[W-2:SW] == '1) && (op_y_q[SW-1:0] != '0);
      spec_d     = 1'b1;
      spec_res_d = '0;
      if (x_nan || y_nan)
         spec_res_d = QNAN;
      else if (x_inf && y_inf)
         spec_res_d = (op_x_q[W-1] != sy_eff) ? QNAN : (POS_INF | {op_x_q[W-1], {(W-1){1'b0}}});
      else if (x_inf)
         spec_res_d = POS_INF | {op_x_q[W-1], {(W-1){1'b0}}};
      else if (y_inf)
         spec_res_d = POS_INF | {sy_eff, {(W-1){1'b0}}};
      else if (x_zero && y_zero)
         spec_res_d = '0;
      else if (y_zero)
         spec_res_d = op_x_q;
      else if (x_zero)
         spec_res_d = {sy_eff, op_y_q[W-2:0]};
      else
         spec_d = 1'b0;
   end

   logic x_ge;
   assign x_ge = ({ex_q, mx_q} >= {ey_q, my_q});

   // Align: bits shifted past the sticky position collapse into bit 0.
   logic [4:0]      d_sat;
   logic [2*XW-2:0] al_ext;
   logic [XW-1:0]   mb_al_d, sum_d;

   always_comb begin
      d_sat   = (d_q > EW'(XW - 1)) ? 5'(XW - 1) : d_q[4:0];
      al_ext  = {1'b0, mb_q, 3'b000, {(XW-1){1'b0}}} >> d_sat;
      mb_al_d = al_ext[2*XW-2:XW-1] | {{(XW-1){1'b0}}, |al_ext[XW-2:0]};
      sum_d   = eff_sub_q ? ({1'b0, ma_q, 3'b000} - mb_al_q)
                          : ({1'b0, ma_q, 3'b000} + mb_al_q);
   end

   logic [4:0]    lz, nshift;
   logic [9:0]    nexp_d;
   logic [SW-1:0] nfrac_d;

   fp_lzc u_lzc (
      .din (sum_q),
      .cnt (lz)
   );

   always_comb begin
      nshift = lz - 5'd1;
      if (sum_q[XW-1]) begin
         nexp_d  = {2'b00, ea_q} + 10'd1;
         nfrac_d = SW'(sum_q >> 4);
      end else begin
         nexp_d  = {2'b00, ea_q} - {5'b00000, nshift};
         nfrac_d = SW'((sum_q << nshift) >> 3);
      end
   end

   // Truncation: G/R/S are simply dropped; nexp_q[9] marks a negative exponent.
   logic [W-1:0] result_d;
   logic         ovf_d, unf_d;

   always_comb begin
      result_d = {sa_q, nexp_q[EW-1:0], nfrac_q};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (spec_q) begin
         result_d = spec_res_q;
      end else if (nzero_q) begin
         result_d = '0;
      end else if (nexp_q[9] || nexp_q == '0) begin
         result_d = {sa_q, {(W-1){1'b0}}};
         unf_d    = 1'b1;
      end else if (nexp_q >= 10'(EXP_MAX)) begin
         result_d = POS_INF | {sa_q, {(W-1){1'b0}}};
         ovf_d    = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.Begin_SUM) begin
               accept  = 1'b1;
               state_d = ST_UNPACK;
            end
         end
         ST_UNPACK: state_d = ST_SWAP;
         ST_SWAP:   state_d = ST_ALIGN;
         ST_ALIGN:  state_d = ST_ADD;
         ST_ADD:    state_d = ST_NORM;
         ST_NORM:   state_d = ST_PACK;
         ST_PACK:   state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               op_x_q <= bus.Data_X;
               op_y_q <= bus.Data_Y;
               sub_q  <= bus.ADD_SUBT;
            end
         end
         ST_UNPACK: begin
            sx_q       <= op_x_q[W-1];
            sy_q       <= sy_eff;
            ex_q       <= op_x_q[W-2:SW];
            ey_q       <= op_y_q[W-2:SW];
            mx_q       <= {1'b1, op_x_q[SW-1:0]};
            my_q       <= {1'b1, op_y_q[SW-1:0]};
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
         end
         ST_SWAP: begin
            sa_q      <= x_ge ? sx_q : sy_q;
            ea_q      <= x_ge ? ex_q : ey_q;
            ma_q      <= x_ge ? mx_q : my_q;
            mb_q      <= x_ge ? my_q : mx_q;
            d_q       <= x_ge ? (ex_q - ey_q) : (ey_q - ex_q);
            eff_sub_q <= sx_q ^ sy_q;
         end
         ST_ALIGN: mb_al_q <= mb_al_d;
         ST_ADD:   sum_q   <= sum_d;
         ST_NORM: begin
            nexp_q  <= nexp_d;
            nfrac_q <= nfrac_d;
            nzero_q <= (sum_q == '0);
         end
         default: ;
      endcase
   end

   // ACK rises one cycle after the result lands, giving the 7-edge latency.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         ack_q    <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ack_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else if (state_q == ST_PACK) begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
         end else if (state_q == ST_DONE) begin
            ack_q <= 1'b1;
         end
      end
   end

   assign bus.Result         = result_q;
   assign bus.ACK_ADD_SUBT   = ack_q;
   assign bus.overflow_flag  = ovf_q;
   assign bus.underflow_flag = unf_q;

endmodule

// File: tb/tb_fp_add_subt_unit.sv
// Directed self-checking bench for fp_add_subt_unit: latency, handshake,
// reset, cancellation, truncation and special-value handling.
module tb_fp_add_subt_unit;
   import fp_pkg::*;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic        sub;
      logic [31:0] res;
      logic        ovf;
      logic        unf;
   } vec_t;

   localparam int NSPEC = 10;
   localparam vec_t SPECIAL [NSPEC] = '{
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0},
      '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0},
      '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0},
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0},
      '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 1'b0, 1'b1},
      '{32'h40490FDB, 32'h00000000, 1'b1, 32'h40490FDB, 1'b0, 1'b0},
      '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b0},
      '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0},
      '{32'hC0A00000, 32'h40400000, 1'b0, 32'hC0000000, 1'b0, 1'b0}
   };

   logic CLK = 1'b0;
   logic RST;
   int   checks   = 0;
   int   failures = 0;

   fp_add_subt_unit_if bus ();

   fp_add_subt_unit dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Present a one-cycle start pulse; returns 1 ns after the sampling edge.
   task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic sub);
      bus.Data_X    = x;
      bus.Data_Y    = y;
      bus.ADD_SUBT  = sub;
      bus.Begin_SUM = 1'b1;
      @(posedge CLK); #1;
      bus.Begin_SUM = 1'b0;
   endtask

   task automatic wait_ack(output int cycles);
      cycles = 0;
      while (bus.ACK_ADD_SUBT !== 1'b1 && cycles < 40) begin
         @(posedge CLK); #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) begin @(posedge CLK); #1; end
      checks++;
      if (bus.Result !== 32'h0) begin
         failures++; $display("FAIL reset_result: got %h expected 00000000", bus.Result);
      end
      checks++;
      if ({bus.ACK_ADD_SUBT, bus.overflow_flag, bus.underflow_flag} !== 3'b000) begin
         failures++; $display("FAIL reset_ack_flags: got %b expected 000",
                              {bus.ACK_ADD_SUBT, bus.overflow_flag, bus.underflow_flag});
      end
      RST = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_add_basic();
      int cyc;
      start_op(32'h3F800000, 32'h40000000, 1'b0);
      wait_ack(cyc);
      checks++;
      if (cyc !== 7) begin failures++; $display("FAIL add_latency: got %0d expected 7", cyc); end
      checks++;
      if (bus.Result !== 32'h40400000) begin
         failures++; $display("FAIL add_result: got %h expected 40400000", bus.Result);
      end
      checks++;
      if ({bus.overflow_flag, bus.underflow_flag} !== 2'b00) begin
         failures++; $display("FAIL add_flags: got %b expected 00", {bus.overflow_flag, bus.underflow_flag});
      end
   endtask

   task automatic test_cancel();
      int cyc;
      start_op(32'h3F800000, 32'h3F800000, 1'b1);
      wait_ack(cyc);
      checks++;
      if (bus.Result !== 32'h00000000) begin
         failures++; $display("FAIL cancel_zero: got %h expected 00000000", bus.Result);
      end
      checks++;
      if (bus.underflow_flag !== 1'b0) begin
         failures++; $display("FAIL cancel_zero_unf: got %b expected 0", bus.underflow_flag);
      end
      start_op(32'h3F800000, 32'h3F7FFFFF, 1'b1);
      wait_ack(cyc);
      checks++;
      if (cyc !== 7 || bus.Result !== 32'h33800000) begin
         failures++; $display("FAIL cancel_massive: got %h after %0d cycles expected 33800000 after 7",
                              bus.Result, cyc);
      end
   endtask

   task automatic test_special();
      int   cyc;
      vec_t v;
      for (int i = 0; i < NSPEC; i++) begin
         v = SPECIAL[i];
         start_op(v.x, v.y, v.sub);
         wait_ack(cyc);
         checks++;
         if (cyc !== 7 || bus.Result !== v.res) begin
            failures++; $display("FAIL special_%0d: got %h after %0d cycles expected %h after 7",
                                 i, bus.Result, cyc, v.res);
         end
         checks++;
         if ({bus.overflow_flag, bus.underflow_flag} !== {v.ovf, v.unf}) begin
            failures++; $display("FAIL special_flags_%0d: got %b expected %b", i,
                                 {bus.overflow_flag, bus.underflow_flag}, {v.ovf, v.unf});
         end
      end
   endtask

   task automatic test_back_to_back();
      int   cyc;
      logic dropped;
      start_op(32'h3F800000, 32'h40000000, 1'b0);
      repeat (2) begin @(posedge CLK); #1; end
      // Second start lands at edge 3 while busy and must be ignored.
      start_op(32'h42280000, 32'h41200000, 1'b1);
      wait_ack(cyc);
      checks++;
      if (cyc !== 4) begin failures++; $display("FAIL busy_latency: got %0d expected 4", cyc); end
      checks++;
      if (bus.Result !== 32'h40400000) begin
         failures++; $display("FAIL busy_ignored: got %h expected 40400000", bus.Result);
      end
      dropped = 1'b0;
      repeat (20) begin
         @(posedge CLK); #1;
         if (bus.ACK_ADD_SUBT !== 1'b1 || bus.Result !== 32'h40400000) dropped = 1'b1;
      end
      checks++;
      if (dropped !== 1'b0) begin failures++; $display("FAIL ack_hold: got drop=%b expected 0", dropped); end
      start_op(32'h42280000, 32'h41200000, 1'b1);
      checks++;
      if (bus.ACK_ADD_SUBT !== 1'b0) begin
         failures++; $display("FAIL ack_clear: got %b expected 0", bus.ACK_ADD_SUBT);
      end
      wait_ack(cyc);
      checks++;
      if (cyc !== 7 || bus.Result !== 32'h42000000) begin
         failures++; $display("FAIL restart: got %h after %0d cycles expected 42000000 after 7",
                              bus.Result, cyc);
      end
   endtask

   task automatic test_reset_midop();
      int cyc;
      start_op(32'h3F800000, 32'h3F800000, 1'b0);
      repeat (4) begin @(posedge CLK); #1; end
      RST = 1'b1;
      #1;
      checks++;
      if (bus.Result !== 32'h0 || bus.ACK_ADD_SUBT !== 1'b0) begin
         failures++; $display("FAIL midop_reset: got result=%h ack=%b expected 00000000/0",
                              bus.Result, bus.ACK_ADD_SUBT);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (8) begin @(posedge CLK); #1; end
      checks++;
      if (bus.ACK_ADD_SUBT !== 1'b0) begin
         failures++; $display("FAIL midop_discard: got ack=%b expected 0", bus.ACK_ADD_SUBT);
      end
      start_op(32'hC0A00000, 32'h40400000, 1'b0);
      wait_ack(cyc);
      checks++;
      if (cyc !== 7 || bus.Result !== 32'hC0000000) begin
         failures++; $display("FAIL post_reset_op: got %h after %0d cycles expected c0000000 after 7",
                              bus.Result, cyc);
      end
   endtask

   task automatic test_truncation();
      int cyc;
      start_op(32'h3F800000, 32'h33000000, 1'b0);
      wait_ack(cyc);
      checks++;
      if (bus.Result !== 32'h3F800000) begin
         failures++; $display("FAIL trunc_add: got %h expected 3f800000", bus.Result);
      end
      start_op(32'h3F800000, 32'h33000000, 1'b1);
      wait_ack(cyc);
      checks++;
      if (bus.Result !== 32'h3F7FFFFF) begin
         failures++; $display("FAIL trunc_sub: got %h expected 3f7fffff", bus.Result);
      end
      // Far-out operand: only sticky survives alignment.
      start_op(32'h3F800000, 32'h2F800000, 1'b1);
      wait_ack(cyc);
      checks++;
      if (bus.Result !== 32'h3F7FFFFF) begin
         failures++; $display("FAIL trunc_sticky_far: got %h expected 3f7fffff", bus.Result);
      end
   endtask

   initial begin
      RST           = 1'b1;
      bus.Begin_SUM = 1'b0;
      bus.ADD_SUBT  = 1'b0;
      bus.Data_X    = '0;
      bus.Data_Y    = '0;
      test_reset();
      test_add_basic();
      test_cancel();
      test_special();
      test_back_to_back();
      test_reset_midop();
      test_truncation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
